// File: rtl/button_pulse_gen.sv
// button_pulse_gen: synchronize, debounce and one-shot pushbuttons, with hold-to-repeat on masked channels.
module button_pulse_gen #(
  parameter int NUM_BTN = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK = 5'b00011
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               any_held
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  typedef enum logic [1:0] {IDLE, HELD, HELD_NOREP, REPEAT} state_t;
  logic [NUM_BTN-1:0] r_s1, r_s2;
  logic               r_any;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_any <= 1'b0;
    end else begin
      r_s1  <= btn_raw;
      r_s2  <= r_s1;
      r_any <= |btn_level;
    end
  end
  assign any_held = r_any;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic [DW-1:0] r_cnt;
    logic [TW-1:0] r_tmr;
    logic          r_lvl, r_pulse;
    state_t        r_st;
    logic          w_chg, w_rise, w_lvl_nxt;
    assign w_chg     = (r_s2[i] != r_lvl) && (r_cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign w_rise    = w_chg & r_s2[i];
    assign w_lvl_nxt = w_chg ? r_s2[i] : r_lvl;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (r_s2[i] == r_lvl) begin
        r_cnt <= '0;
      end else if (w_chg) begin
        r_lvl <= r_s2[i];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DW'(1);
      end
    end
    // FSM looks at the next debounced level so a release edge can never carry a pulse
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_st    <= IDLE;
        r_tmr   <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        if (!w_lvl_nxt) begin
          r_st  <= IDLE;
          r_tmr <= '0;
        end else begin
          case (r_st)
            IDLE: if (w_rise) begin
              r_pulse <= 1'b1;
              r_st    <= REPEAT_MASK[i] ? HELD : HELD_NOREP;
              r_tmr   <= '0;
            end
            HELD: if (r_tmr == TW'(HOLD_CYCLES - 1)) begin
              r_pulse <= 1'b1;
              r_st    <= REPEAT;
              r_tmr   <= '0;
            end else r_tmr <= r_tmr + TW'(1);
            REPEAT: if (r_tmr == TW'(REPEAT_CYCLES - 1)) begin
              r_pulse <= 1'b1;
              r_tmr   <= '0;
            end else r_tmr <= r_tmr + TW'(1);
            default: r_tmr <= '0;
          endcase
        end
      end
    end
    assign btn_level[i] = r_lvl;
    assign btn_pulse[i] = r_pulse;
  end
endmodule

// File: tb/tb_button_pulse_gen.sv
// tb_button_pulse_gen: directed scenarios with a queue of expected pulse edges and per-bit level windows.
module tb_button_pulse_gen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn_raw = '0;
  logic [4:0] btn_level, btn_pulse;
  logic       any_held;
  typedef struct {int e; logic [4:0] v;} exp_t;
  exp_t       q[$];
  int         rise_e[5], fall_e[5];
  int         cyc, vecs, errs;
  logic [4:0] pl;
  always #5 clk = ~clk;
  button_pulse_gen #(
    .NUM_BTN(5), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_MASK(5'b00011)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .any_held(any_held)
  );
  task automatic cmp(input string tag, input logic [4:0] o, input logic [4:0] e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, o, e);
    end
  endtask
  task automatic qempty(input string tag);
    vecs++;
    assert (q.size() == 0) else begin
      errs++;
      $error("FAIL %s pending_pulses observed=%0d expected=0", tag, q.size());
    end
    q.delete();
  endtask
  function automatic logic [4:0] explvl(input int c);
    logic [4:0] r = '0;
    for (int b = 0; b < 5; b++) r[b] = (c >= rise_e[b]) && (c < fall_e[b]);
    return r;
  endfunction
  task automatic clr();
    for (int b = 0; b < 5; b++) begin
      rise_e[b] = 1000000;
      fall_e[b] = 1000000;
    end
    cyc = 0;
  endtask
  task automatic push(input int e, input logic [4:0] v);
    exp_t x;
    x.e = e;
    x.v = v;
    q.push_back(x);
  endtask
  task automatic tick();
    logic [4:0] ep, el;
    @(posedge clk);
    cyc++;
    #1;
    el = explvl(cyc);
    ep = 5'b0;
    if (q.size() > 0 && q[0].e == cyc) begin
      ep = q[0].v;
      q.delete(0);
    end
    cmp("pulse", btn_pulse, ep);
    cmp("level", btn_level, el);
    cmp("any_held", {4'b0, any_held}, {4'b0, |pl});
    pl = el;
  endtask
  task automatic run(input int n);
    repeat (n) tick();
  endtask
  task automatic rst_chk(input string tag);
    cmp({tag, "_level"}, btn_level, 5'b0);
    cmp({tag, "_pulse"}, btn_pulse, 5'b0);
    cmp({tag, "_any"}, {4'b0, any_held}, 5'b0);
  endtask
  initial begin
    vecs = 0;
    errs = 0;
    pl = '0;
    clr();
    #2 rst_chk("reset");
    #20 rst_n = 1'b1;
    run(4);
    // clean press and release on right
    clr(); rise_e[3] = 6; fall_e[3] = 26; push(6, 5'b01000);
    btn_raw = 5'b01000; run(20);
    btn_raw = 5'b00000; run(12);
    qempty("t1_clean");
    // bounce on center: final rising sample lands on edge 9
    clr(); rise_e[4] = 14; fall_e[4] = 26; push(14, 5'b10000);
    btn_raw = 5'b10000; run(2);
    btn_raw = 5'b00000; run(2);
    btn_raw = 5'b10000; run(2);
    btn_raw = 5'b00000; run(2);
    btn_raw = 5'b10000; run(12);
    btn_raw = 5'b00000; run(12);
    qempty("t2_bounce");
    // auto-repeat on up; level falls on edge 43, exactly when a repeat would be due
    clr(); rise_e[0] = 6; fall_e[0] = 43; push(6, 5'b00001);
    for (int e = 16; e <= 40; e += 3) push(e, 5'b00001);
    btn_raw = 5'b00001; run(37);
    btn_raw = 5'b00000; run(12);
    qempty("t3_repeat");
    // left is not repeat-enabled
    clr(); rise_e[2] = 6; fall_e[2] = 46; push(6, 5'b00100);
    btn_raw = 5'b00100; run(40);
    btn_raw = 5'b00000; run(12);
    qempty("t4_masked");
    // left and right together
    clr(); rise_e[2] = 6; fall_e[2] = 16; rise_e[3] = 6; fall_e[3] = 16; push(6, 5'b01100);
    btn_raw = 5'b01100; run(10);
    btn_raw = 5'b00000; run(12);
    qempty("t5_simul");
    // reset while down is in HELD
    clr(); rise_e[1] = 6; push(6, 5'b00010);
    btn_raw = 5'b00010; run(14);
    rst_n = 1'b0;
    #1 rst_chk("midrst_async");
    @(posedge clk);
    #1 rst_chk("midrst_held");
    rst_n = 1'b1;
    clr(); pl = '0; rise_e[1] = 6; fall_e[1] = 26;
    push(6, 5'b00010);
    for (int e = 16; e <= 25; e += 3) push(e, 5'b00010);
    run(20);
    btn_raw = 5'b00000; run(12);
    qempty("t6_rstpress");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
